pixel_plotter: RTL and testbench

- Sink end of the pixel-coordinate stream that the shape drawers emit.
- Accepts (x, y, color, last) over a valid/ready handshake and buffers it in a small FIFO.
- Converts each coordinate to a linear framebuffer address, clips off-screen points, and issues single-cycle writes to the framebuffer port, honouring a memory stall.
- Pulses done when the pixel tagged last has retired, so a shape drawer's sequence can be acknowledged end-to-end.

---
 rtl/pixel_plotter.sv | 127 ++++++++++++
 tb/tb_pixel_plotter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_plotter.sv
// rtl/pixel_plotter.sv - pixel stream sink: FIFO, clip, linear address, framebuffer write
module pixel_plotter #(
   parameter int WIDTH   = 640,
   parameter int HEIGHT  = 480,
   parameter int COORD_W = 11,
   parameter int ADDR_W  = 19,
   parameter int COLOR_W = 1,
   parameter int DEPTH   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [COORD_W-1:0] in_x,
   input  logic [COORD_W-1:0] in_y,
   input  logic [COLOR_W-1:0] in_color,
   input  logic               in_last,
   input  logic               mem_busy,
   output logic               mem_we,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [COLOR_W-1:0] mem_data,
   output logic               done,
   output logic               busy,
   output logic [15:0]        clip_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = 2 * COORD_W + COLOR_W + 1;
   localparam int PROD_W = 2 * COORD_W;
   localparam logic [COORD_W-1:0] WIDTH_C  = COORD_W'(WIDTH);
   localparam logic [COORD_W-1:0] HEIGHT_C = COORD_W'(HEIGHT);
   localparam logic [PROD_W-1:0]  WIDTH_P  = PROD_W'(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      STALL = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [ENT_W-1:0]   fifo_mem [DEPTH];
   logic [PTR_W:0]     wr_ptr, rd_ptr;
   logic               empty, full, push, pop, last_entry;
   logic [COORD_W-1:0] head_x, head_y;
   logic [COLOR_W-1:0] head_color;
   logic               head_last, in_range;
   logic [PROD_W-1:0]  lin_addr;

   // Extra pointer bit separates full (MSBs differ) from empty (pointers equal)
   assign empty      = (wr_ptr == rd_ptr);
   assign full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign in_ready   = !full;
   assign push       = in_valid && !full;
   assign pop        = (state_q != IDLE) && !empty && !mem_busy;
   assign last_entry = ((rd_ptr + (PTR_W+1)'(1)) == wr_ptr);
   assign busy       = !empty || mem_we;

   assign {head_x, head_y, head_color, head_last} = fifo_mem[rd_ptr[PTR_W-1:0]];

   // Clip on raw coordinates; address computed at full product width then truncated
   assign in_range = (head_x < WIDTH_C) && (head_y < HEIGHT_C);
   assign lin_addr = {{COORD_W{1'b0}}, head_y} * WIDTH_P + {{COORD_W{1'b0}}, head_x};

   // FIFO storage: contents need no reset, pointers qualify them
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[PTR_W-1:0]] <= {in_x, in_y, in_color, in_last};
      end
   end

   // FIFO pointers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state: drain while data is present, park in STALL behind the memory
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (push) state_d = DRAIN;
         end
         DRAIN, STALL: begin
            if (pop && last_entry && !push) state_d = IDLE;
            else if (mem_busy && !empty)    state_d = STALL;
            else                            state_d = DRAIN;
         end
         default: state_d = IDLE;
      endcase
   end

   // Retire stage: registered write strobe, address/data, done pulse and clip counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= '0;
         done       <= 1'b0;
         clip_count <= '0;
      end else begin
         mem_we <= pop && in_range;
         done   <= pop && head_last;
         if (pop && in_range) begin
            mem_addr <= lin_addr[ADDR_W-1:0];
            mem_data <= head_color;
         end
         if (pop && !in_range && (clip_count != 16'hFFFF)) begin
            clip_count <= clip_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_pixel_plotter.sv
// tb/tb_pixel_plotter.sv - directed self-checking bench for pixel_plotter
module tb_pixel_plotter;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [10:0] in_x;
   logic [10:0] in_y;
   logic [0:0]  in_color;
   logic        in_last;
   logic        mem_busy;
   logic        mem_we;
   logic [18:0] mem_addr;
   logic [0:0]  mem_data;
   logic        done;
   logic        busy;
   logic [15:0] clip_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = -1;
   bit rand_busy = 0;
   logic [18:0] wa[$];
   logic [0:0]  wd[$];
   int          wc[$];

   pixel_plotter dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_x       (in_x),
      .in_y       (in_y),
      .in_color   (in_color),
      .in_last    (in_last),
      .mem_busy   (mem_busy),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .done       (done),
      .busy       (busy),
      .clip_count (clip_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cycle counter
   always @(posedge clk) cyc++;

   // write/done monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wa.push_back(mem_addr);
         wd.push_back(mem_data);
         wc.push_back(cyc);
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      wa.delete();
      wd.delete();
      wc.delete();
      done_cnt = 0;
      done_cyc = -1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      mem_busy = 1'b0;
      rand_busy = 0;
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      clear_mon();
   endtask

   task automatic push(input int x, input int y, input int c, input int l);
      bit r;
      int guard;
      in_x = 11'(x);
      in_y = 11'(y);
      in_color = 1'(c);
      in_last = 1'(l);
      in_valid = 1'b1;
      guard = 0;
      do begin
         r = in_ready;
         if (rand_busy) mem_busy = 1'($urandom_range(0, 1));
         tick();
         guard++;
      end while (!r && guard < 200);
      in_valid = 1'b0;
      if (rand_busy) mem_busy = 1'($urandom_range(0, 1));
      if (!r) chk("push_accept", {31'd0, r}, 32'd1);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((busy !== 1'b0) && guard < 300) begin
         if (rand_busy) mem_busy = 1'($urandom_range(0, 1));
         tick();
         guard++;
      end
      rand_busy = 0;
      mem_busy = 1'b0;
      tick();
      chk("drain_idle", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int bad;
      in_valid = 1'b0;
      in_x = '0;
      in_y = '0;
      in_color = '0;
      in_last = 1'b0;
      mem_busy = 1'b0;
      reset = 1'b1;
      #2;
      do_reset();

      // reset state
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", {13'd0, mem_addr}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_clip", {16'd0, clip_count}, 32'd0);

      // basic write: push at edge N, write visible after edge N+1
      in_x = 11'd20; in_y = 11'd20; in_color = 1'b1; in_last = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("basic_we_early", {31'd0, mem_we}, 32'd0);
      chk("basic_busy", {31'd0, busy}, 32'd1);
      tick();
      chk("basic_we", {31'd0, mem_we}, 32'd1);
      chk("basic_addr", {13'd0, mem_addr}, 32'd12820);
      chk("basic_data", {31'd0, mem_data}, 32'd1);
      chk("basic_done", {31'd0, done}, 32'd1);
      tick();
      chk("basic_we_off", {31'd0, mem_we}, 32'd0);
      chk("basic_done_off", {31'd0, done}, 32'd0);
      chk("basic_idle", {31'd0, busy}, 32'd0);
      chk("basic_addr_hold", {13'd0, mem_addr}, 32'd12820);

      // stream 11x11 back-to-back
      do_reset();
      for (int y = 20; y <= 30; y++)
         for (int x = 20; x <= 30; x++)
            push(x, y, (x + y) % 2, (x == 30 && y == 30) ? 1 : 0);
      drain();
      chk("stream_count", wa.size(), 32'd121);
      if (wa.size() == 121) begin
         chk("stream_first", {13'd0, wa[0]}, 32'd12820);
         chk("stream_final", {13'd0, wa[120]}, 32'd19230);
         chk("stream_nogap", wc[120] - wc[0], 32'd120);
         bad = 0;
         for (int i = 0; i < 121; i++) begin
            if (wa[i] !== 19'((20 + i / 11) * 640 + 20 + i % 11)) bad++;
            if (wd[i] !== 1'((40 + i / 11 + i % 11) % 2)) bad++;
         end
         chk("stream_order", bad, 32'd0);
      end
      chk("stream_done", done_cnt, 32'd1);

      // full/stall
      do_reset();
      mem_busy = 1'b1;
      for (int i = 0; i < 8; i++) push(100 + i, 1, i % 2, 0);
      chk("full_ready", {31'd0, in_ready}, 32'd0);
      repeat (3) tick();
      chk("full_ready_hold", {31'd0, in_ready}, 32'd0);
      chk("full_no_write", wa.size(), 32'd0);
      mem_busy = 1'b0;
      push(108, 1, 0, 1);
      drain();
      chk("full_count", wa.size(), 32'd9);
      if (wa.size() == 9) begin
         bad = 0;
         for (int i = 0; i < 9; i++) if (wa[i] !== 19'(740 + i)) bad++;
         chk("full_order", bad, 32'd0);
         chk("full_consecutive", wc[8] - wc[0], 32'd8);
      end
      chk("full_done", done_cnt, 32'd1);

      // clipping
      do_reset();
      push(640, 0, 1, 0);
      push(0, 480, 1, 0);
      push(639, 479, 1, 1);
      drain();
      chk("clip_writes", wa.size(), 32'd1);
      if (wa.size() == 1) begin
         chk("clip_addr", {13'd0, wa[0]}, 32'd307199);
         chk("clip_done_cycle", done_cyc, wc[0]);
      end
      chk("clip_count", {16'd0, clip_count}, 32'd2);
      chk("clip_done", done_cnt, 32'd1);

      // mid-operation asynchronous reset
      do_reset();
      push(700, 0, 0, 0);
      repeat (2) tick();
      chk("mid_clip_pre", {16'd0, clip_count}, 32'd1);
      mem_busy = 1'b1;
      for (int i = 0; i < 5; i++) push(i, 5, 1, (i == 4) ? 1 : 0);
      chk("mid_busy_pre", {31'd0, busy}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_we", {31'd0, mem_we}, 32'd0);
      chk("mid_busy", {31'd0, busy}, 32'd0);
      chk("mid_clip", {16'd0, clip_count}, 32'd0);
      #1;
      reset = 1'b1;
      clear_mon();
      mem_busy = 1'b0;
      repeat (20) tick();
      chk("mid_no_writes", wa.size(), 32'd0);
      chk("mid_no_done", done_cnt, 32'd0);
      chk("mid_ready", {31'd0, in_ready}, 32'd1);

      // pointer wrap with random stalls
      do_reset();
      rand_busy = 1;
      for (int i = 0; i < 20; i++) push(i, 0, i % 2, (i == 19) ? 1 : 0);
      rand_busy = 1;
      drain();
      chk("wrap_count", wa.size(), 32'd20);
      if (wa.size() == 20) begin
         bad = 0;
         for (int i = 0; i < 20; i++) begin
            if (wa[i] !== 19'(i)) bad++;
            if (wd[i] !== 1'(i % 2)) bad++;
         end
         chk("wrap_order", bad, 32'd0);
      end
      chk("wrap_done", done_cnt, 32'd1);
      chk("wrap_clip", {16'd0, clip_count}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
